// File: rtl/kf8259_init_sequencer_if.sv
// CPU-side register-write bus of the 8259 init sequencer and its decoded configuration outputs.
// The master drives the strobes, data and read level; the slave returns the latched configuration.
interface kf8259_init_sequencer_if;
  logic [7:0] internal_data_bus;
  logic       write_initial_command_word_1;
  logic       write_initial_command_word_2_4;
  logic       write_operation_control_word_1;
  logic       write_operation_control_word_2;
  logic       write_operation_control_word_3;
  logic       read;

  logic       level_or_edge_triggered;
  logic       single_or_cascade;
  logic [4:0] interrupt_vector_base;
  logic [7:0] cascade_device_config;
  logic       auto_eoi;
  logic       buffered_mode;
  logic       buffered_master_or_slave;
  logic       special_fully_nested;
  logic       u8086_or_mcs80;
  logic [7:0] interrupt_mask;
  logic       ocw2_strobe;
  logic [2:0] ocw2_command;
  logic [2:0] ocw2_level;
  logic       special_mask_mode;
  logic       read_isr_not_irr;
  logic       poll_command;
  logic       initialization_busy;

  modport master (
    output internal_data_bus, write_initial_command_word_1, write_initial_command_word_2_4,
           write_operation_control_word_1, write_operation_control_word_2,
           write_operation_control_word_3, read,
    input  level_or_edge_triggered, single_or_cascade, interrupt_vector_base,
           cascade_device_config, auto_eoi, buffered_mode, buffered_master_or_slave,
           special_fully_nested, u8086_or_mcs80, interrupt_mask, ocw2_strobe,
           ocw2_command, ocw2_level, special_mask_mode, read_isr_not_irr,
           poll_command, initialization_busy
  );

  modport slave (
    input  internal_data_bus, write_initial_command_word_1, write_initial_command_word_2_4,
           write_operation_control_word_1, write_operation_control_word_2,
           write_operation_control_word_3, read,
    output level_or_edge_triggered, single_or_cascade, interrupt_vector_base,
           cascade_device_config, auto_eoi, buffered_mode, buffered_master_or_slave,
           special_fully_nested, u8086_or_mcs80, interrupt_mask, ocw2_strobe,
           ocw2_command, ocw2_level, special_mask_mode, read_isr_not_irr,
           poll_command, initialization_busy
  );
endinterface

// File: rtl/kf8259_init_sequencer.sv
// 8259 ICW1..ICW4 initialization sequencer plus OCW1/2/3 register decode.
// Every output is registered and updates one cycle after its strobe; strobes are never back-pressured.
module kf8259_init_sequencer (
  input logic                    clock,
  input logic                    reset,
  kf8259_init_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } state_t;

  state_t     state;
  logic       ic4;
  logic       read_d;
  logic       read_fall;

  logic       ltim;
  logic       sngl;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
  logic       aeoi;
  logic       buf_mode;
  logic       buf_ms;
  logic       sfnm;
  logic       upm;
  logic [7:0] imr;
  logic       ocw2_pulse;
  logic [2:0] ocw2_cmd;
  logic [2:0] ocw2_lvl;
  logic       smm;
  logic       ris;
  logic       poll;
  logic       busy;

  logic [7:0] data;
  assign data      = bus.internal_data_bus;
  assign read_fall = read_d & ~bus.read;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= READY;
      busy        <= 1'b0;
      ic4         <= 1'b0;
      read_d      <= 1'b0;
      ltim        <= 1'b0;
      sngl        <= 1'b0;
      vector_base <= 5'd0;
      cascade_cfg <= 8'd0;
      aeoi        <= 1'b0;
      buf_mode    <= 1'b0;
      buf_ms      <= 1'b0;
      sfnm        <= 1'b0;
      upm         <= 1'b0;
      imr         <= 8'd0;
      ocw2_pulse  <= 1'b0;
      ocw2_cmd    <= 3'd0;
      ocw2_lvl    <= 3'd0;
      smm         <= 1'b0;
      ris         <= 1'b0;
      poll        <= 1'b0;
    end else begin
      ocw2_pulse <= 1'b0;
      read_d     <= bus.read;
      // A poll set later in this block overrides this clear when both land together.
      if (read_fall) begin
        poll <= 1'b0;
      end

      if (bus.write_initial_command_word_1) begin
        state <= WAIT_ICW2;
        busy  <= 1'b1;
        ltim  <= data[3];
        sngl  <= data[1];
        ic4   <= data[0];
        imr   <= 8'd0;
        smm   <= 1'b0;
        ris   <= 1'b0;
        poll  <= 1'b0;
        if (!data[0]) begin
          aeoi     <= 1'b0;
          buf_mode <= 1'b0;
          buf_ms   <= 1'b0;
          sfnm     <= 1'b0;
          upm      <= 1'b0;
        end
      end else begin
        case (state)
          READY: begin
            if (bus.write_operation_control_word_1) begin
              imr <= data;
            end
            if (bus.write_operation_control_word_2) begin
              ocw2_pulse <= 1'b1;
              ocw2_cmd   <= data[7:5];
              ocw2_lvl   <= data[2:0];
            end
            if (bus.write_operation_control_word_3) begin
              if (data[6]) begin
                smm <= data[5];
              end
              if (data[1]) begin
                ris <= data[0];
              end
              if (data[2]) begin
                poll <= 1'b1;
              end
            end
          end
          WAIT_ICW2: begin
            if (bus.write_initial_command_word_2_4) begin
              vector_base <= data[7:3];
              if (!sngl) begin
                state <= WAIT_ICW3;
              end else if (ic4) begin
                state <= WAIT_ICW4;
              end else begin
                state <= READY;
                busy  <= 1'b0;
              end
            end
          end
          WAIT_ICW3: begin
            if (bus.write_initial_command_word_2_4) begin
              cascade_cfg <= data;
              if (ic4) begin
                state <= WAIT_ICW4;
              end else begin
                state <= READY;
                busy  <= 1'b0;
              end
            end
          end
          WAIT_ICW4: begin
            if (bus.write_initial_command_word_2_4) begin
              upm      <= data[0];
              aeoi     <= data[1];
              buf_ms   <= data[2];
              buf_mode <= data[3];
              sfnm     <= data[4];
              state    <= READY;
              busy     <= 1'b0;
            end
          end
          default: begin
            state <= READY;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.level_or_edge_triggered  = ltim;
  assign bus.single_or_cascade        = sngl;
  assign bus.interrupt_vector_base    = vector_base;
  assign bus.cascade_device_config    = cascade_cfg;
  assign bus.auto_eoi                 = aeoi;
  assign bus.buffered_mode            = buf_mode;
  assign bus.buffered_master_or_slave = buf_ms;
  assign bus.special_fully_nested     = sfnm;
  assign bus.u8086_or_mcs80           = upm;
  assign bus.interrupt_mask           = imr;
  assign bus.ocw2_strobe              = ocw2_pulse;
  assign bus.ocw2_command             = ocw2_cmd;
  assign bus.ocw2_level               = ocw2_lvl;
  assign bus.special_mask_mode        = smm;
  assign bus.read_isr_not_irr         = ris;
  assign bus.poll_command             = poll;
  assign bus.initialization_busy      = busy;

endmodule

// File: tb/tb_kf8259_init_sequencer.sv
// Bench for kf8259_init_sequencer: directed scenarios then random traffic against a queue-based model.
module tb_kf8259_init_sequencer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  kf8259_init_sequencer_if bus ();
  kf8259_init_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model: the ICW words still owed after ICW1 are held as a queue of word numbers.
  int         pending[$];
  logic       m_ltim, m_sngl, m_aeoi, m_buf, m_ms, m_sfnm, m_upm;
  logic [4:0] m_base;
  logic [7:0] m_cas, m_mask;
  logic       m_strobe, m_smm, m_ris, m_poll, m_read_prev;
  logic [2:0] m_cmd, m_lvl;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [7:0] d;
    logic fall, ready;
    int k;
    d = bus.internal_data_bus;
    if (!reset) begin
      pending.delete();
      {m_ltim, m_sngl, m_aeoi, m_buf, m_ms, m_sfnm, m_upm} = '0;
      m_base = '0; m_cas = '0; m_mask = '0;
      {m_strobe, m_smm, m_ris, m_poll, m_read_prev} = '0;
      m_cmd = '0; m_lvl = '0;
      return;
    end
    fall = m_read_prev && !bus.read;
    m_read_prev = bus.read;
    ready = (pending.size() == 0);
    m_strobe = 1'b0;
    if (fall) m_poll = 1'b0;
    if (bus.write_initial_command_word_1) begin
      m_ltim = d[3]; m_sngl = d[1];
      m_mask = 8'h00; m_smm = 0; m_ris = 0; m_poll = 0;
      if (!d[0]) {m_aeoi, m_buf, m_ms, m_sfnm, m_upm} = '0;
      pending.delete();
      pending.push_back(2);
      if (!d[1]) pending.push_back(3);
      if (d[0]) pending.push_back(4);
    end else begin
      if (bus.write_initial_command_word_2_4) begin
        if (ready) m_mask = d;
        else begin
          k = pending.pop_front();
          case (k)
            2: m_base = d[7:3];
            3: m_cas = d;
            default: begin
              m_upm = d[0]; m_aeoi = d[1]; m_ms = d[2]; m_buf = d[3]; m_sfnm = d[4];
            end
          endcase
        end
      end
      if (ready && bus.write_operation_control_word_2) begin
        m_strobe = 1'b1; m_cmd = d[7:5]; m_lvl = d[2:0];
      end
      if (ready && bus.write_operation_control_word_3) begin
        if (d[6]) m_smm = d[5];
        if (d[1]) m_ris = d[0];
        if (d[2]) m_poll = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("busy", bus.initialization_busy, pending.size() != 0);
    chk("ltim", bus.level_or_edge_triggered, m_ltim);
    chk("sngl", bus.single_or_cascade, m_sngl);
    chk("vector_base", bus.interrupt_vector_base, m_base);
    chk("cascade", bus.cascade_device_config, m_cas);
    chk("icw4_bits", {bus.special_fully_nested, bus.buffered_mode, bus.buffered_master_or_slave,
                      bus.auto_eoi, bus.u8086_or_mcs80}, {m_sfnm, m_buf, m_ms, m_aeoi, m_upm});
    chk("mask", bus.interrupt_mask, m_mask);
    chk("ocw2", {bus.ocw2_strobe, bus.ocw2_command, bus.ocw2_level}, {m_strobe, m_cmd, m_lvl});
    chk("ocw3", {bus.special_mask_mode, bus.read_isr_not_irr, bus.poll_command}, {m_smm, m_ris, m_poll});
  endtask

  task automatic drive(input logic icw1, input logic a0, input logic o2, input logic o3,
                       input logic [7:0] d);
    bus.write_initial_command_word_1   = icw1;
    bus.write_initial_command_word_2_4 = a0;
    bus.write_operation_control_word_1 = a0;
    bus.write_operation_control_word_2 = o2;
    bus.write_operation_control_word_3 = o3;
    bus.internal_data_bus              = d;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
    drive(0, 0, 0, 0, bus.internal_data_bus);
  endtask

  task automatic icw1(input logic [7:0] d); drive(1, 0, 0, 0, d); tick(); endtask
  task automatic a0w(input logic [7:0] d);  drive(0, 1, 0, 0, d); tick(); endtask
  task automatic ocw2(input logic [7:0] d); drive(0, 0, 1, 0, d); tick(); endtask
  task automatic ocw3(input logic [7:0] d); drive(0, 0, 0, 1, d); tick(); endtask

  initial begin
    int r;
    reset = 1'b0;
    bus.read = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    tick();
    tick();
    chk("reset_busy", bus.initialization_busy, 1'b0);
    chk("reset_mask", bus.interrupt_mask, 8'h00);
    reset = 1'b1;
    tick();

    // Single, ICW4 needed, no ICW3.
    icw1(8'h13);
    chk("d1_busy_hi", bus.initialization_busy, 1'b1);
    a0w(8'h08);
    chk("d1_still_busy", bus.initialization_busy, 1'b1);
    a0w(8'h01);
    chk("d1_busy_lo", bus.initialization_busy, 1'b0);
    chk("d1_base", bus.interrupt_vector_base, 5'b00001);
    chk("d1_sngl", bus.single_or_cascade, 1'b1);
    chk("d1_upm", bus.u8086_or_mcs80, 1'b1);

    // Cascade with ICW3 and ICW4.
    icw1(8'h11);
    a0w(8'h70);
    a0w(8'h04);
    a0w(8'h03);
    chk("d2_cas", bus.cascade_device_config, 8'h04);
    chk("d2_aeoi", bus.auto_eoi, 1'b1);
    chk("d2_base", bus.interrupt_vector_base, 5'b01110);
    chk("d2_busy", bus.initialization_busy, 1'b0);

    a0w(8'hFB);
    chk("d3_mask", bus.interrupt_mask, 8'hFB);
    icw1(8'h11);
    chk("d3_mask_clr", bus.interrupt_mask, 8'h00);
    chk("d3_busy", bus.initialization_busy, 1'b1);

    ocw2(8'h20);
    chk("d4_no_pulse", bus.ocw2_strobe, 1'b0);
    a0w(8'h70);
    a0w(8'h04);
    a0w(8'h03);
    ocw2(8'h20);
    chk("d4_pulse", bus.ocw2_strobe, 1'b1);
    chk("d4_cmd", bus.ocw2_command, 3'b001);
    tick();
    chk("d4_pulse_end", bus.ocw2_strobe, 1'b0);

    ocw3(8'h0C);
    chk("d5_poll_set", bus.poll_command, 1'b1);
    bus.read = 1'b1;
    tick();
    chk("d5_poll_hold", bus.poll_command, 1'b1);
    bus.read = 1'b0;
    tick();
    chk("d5_poll_clr", bus.poll_command, 1'b0);
    bus.read = 1'b1;
    ocw3(8'h0C);
    bus.read = 1'b0;
    ocw3(8'h0C);
    chk("d5_set_wins", bus.poll_command, 1'b1);
    ocw3(8'h6B);
    chk("d5_smm", bus.special_mask_mode, 1'b1);
    chk("d5_ris", bus.read_isr_not_irr, 1'b1);

    // Reset in WAIT_ICW3 colliding with the ICW3 write.
    icw1(8'h11);
    a0w(8'h70);
    reset = 1'b0;
    a0w(8'h55);
    chk("d6_busy", bus.initialization_busy, 1'b0);
    chk("d6_cas", bus.cascade_device_config, 8'h00);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) bus.read = ~bus.read;
      r = $urandom_range(0, 99);
      if (r < 6)       drive(1, 0, 0, 0, 8'($urandom) | 8'h10);
      else if (r < 40) drive(0, 1, 0, 0, 8'($urandom));
      else if (r < 55) drive(0, 0, 1, 0, 8'($urandom));
      else if (r < 75) drive(0, 0, 0, 1, 8'($urandom));
      else             drive(0, 0, 0, 0, 8'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
